// File: rtl/sfr_pkg.sv
// Shared definitions for the shift-register SFR link: state encoding and
// handshake timing constants used by transmit and future receive blocks.
package sfr_pkg;

  localparam int unsigned SFR_DEFAULT_SIZE = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_SEND  = ST_SEND,
    S_DONE  = ST_DONE
  } state_t;

  // Link handshake: one clear cycle, SIZE shift steps, one done cycle.
  localparam int unsigned SFR_CLEAR_CYCLES = 1;
  localparam int unsigned SFR_DONE_CYCLES  = 1;

  // Accept-to-next-accept spacing of an unpaused word.
  function automatic int unsigned sfr_tx_spacing(input int unsigned size);
    return size + SFR_CLEAR_CYCLES + SFR_DONE_CYCLES + 1;
  endfunction

endpackage

// File: rtl/sfr_word_tx_if.sv
// Word handshake plus SFR control stream of the SFR link transmitter.
interface sfr_word_tx_if
  import sfr_pkg::*;
#(
  parameter int unsigned SIZE = SFR_DEFAULT_SIZE
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] din;
  logic            pause;
  logic            sfr_clr;
  logic            sfr_left;
  logic            sfr_incr;
  logic            busy;
  logic            done;

  modport master (
    output in_valid, din, pause,
    input  in_ready, sfr_clr, sfr_left, sfr_incr, busy, done
  );

  modport slave (
    input  in_valid, din, pause,
    output in_ready, sfr_clr, sfr_left, sfr_incr, busy, done
  );
endinterface

// File: rtl/sfr_bit_cnt.sv
// Loadable down-counter with hold and zero flag; counts remaining SFR bits.
module sfr_bit_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sfr_word_tx.sv
// SFR link transmitter: turns an accepted word into a clear/shift/increment
// stream that rebuilds the word MSB first in a downstream left-shift SFR.
module sfr_word_tx
  import sfr_pkg::*;
#(
  parameter int unsigned SIZE = SFR_DEFAULT_SIZE
) (
  input  logic         clk,
  input  logic         clr,
  sfr_word_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SIZE);

  state_t            state, state_n;
  logic [SIZE-1:0]   sr, sr_n;
  logic              stall, stall_n;
  logic              left_q, left_n;
  logic              incr_q, incr_n;
  logic              cnt_load, cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  sfr_bit_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (CNT_W'(SIZE - 1)),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      sr     <= '0;
      stall  <= 1'b0;
      left_q <= 1'b0;
      incr_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      stall  <= stall_n;
      left_q <= left_n;
      incr_q <= incr_n;
    end
  end

  // left/incr are precomputed for the following cycle so they leave a flop.
  // A stalled cycle shows zeros and consumes nothing, so sr/cnt hold in it.
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    stall_n  = 1'b0;
    left_n   = 1'b0;
    incr_n   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          sr_n    = bus.din;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_load = 1'b1;
        state_n  = S_SEND;
        left_n   = 1'b1;
        incr_n   = sr[SIZE-1];
      end
      S_SEND: begin
        if (!stall) begin
          sr_n = {sr[SIZE-2:0], 1'b0};
          if (cnt_zero) begin
            state_n = S_DONE;
          end else begin
            cnt_en  = 1'b1;
            stall_n = bus.pause;
            if (!bus.pause) begin
              left_n = (cnt != CNT_W'(1));
              incr_n = sr[SIZE-2];
            end
          end
        end else begin
          stall_n = bus.pause;
          if (!bus.pause) begin
            left_n = !cnt_zero;
            incr_n = sr[SIZE-1];
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.sfr_clr  = (state == S_CLEAR);
  assign bus.done     = (state == S_DONE);
  assign bus.sfr_left = left_q;
  assign bus.sfr_incr = incr_q;

endmodule

// File: tb/tb_sfr_word_tx.sv
// Bench for sfr_word_tx (SIZE=8): directed and random words with pauses,
// checked against a left-shift SFR model and the source word.
module tb_sfr_word_tx;
  import sfr_pkg::*;

  localparam int unsigned SIZE = 8;

  logic clk;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic [SIZE-1:0] q;

  sfr_word_tx_if #(.SIZE(SIZE)) bus ();

  sfr_word_tx #(.SIZE(SIZE)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream SFR: increment resolves before the left shift.
  always @(posedge clk) begin
    if (bus.sfr_clr)       q <= '0;
    else if (bus.sfr_left) q <= (q + SIZE'(bus.sfr_incr)) << 1;
    else                   q <= q + SIZE'(bus.sfr_incr);
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_sfr_clr"},  32'(bus.sfr_clr),  32'd0);
    check({tag, "_sfr_left"}, 32'(bus.sfr_left), 32'd0);
    check({tag, "_sfr_incr"}, 32'(bus.sfr_incr), 32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
  endtask

  // Expected SEND-cycle stream: word bits MSB first, left on all but the
  // last bit, with pause zero-slots inserted after bit index ps-2.
  function automatic void exp_stream(input logic [SIZE-1:0] w, input int ps, input int pl,
                                     output logic [31:0] el, output logic [31:0] ei,
                                     output int n);
    el = '0; ei = '0; n = 0;
    for (int i = 0; i < int'(SIZE); i++) begin
      el = {el[30:0], (i != int'(SIZE) - 1)};
      ei = {ei[30:0], w[int'(SIZE) - 1 - i]};
      n++;
      if (pl > 0 && i == ps - 2) begin
        for (int j = 0; j < pl; j++) begin
          el = {el[30:0], 1'b0};
          ei = {ei[30:0], 1'b0};
          n++;
        end
      end
    end
  endfunction

  // Sends one word. Cycle k counts from the accept edge (cycle 0).
  task automatic send_word(input logic [SIZE-1:0] w, input int ps, input int pl,
                           input int junk_k, input int abort_k, input bit chain,
                           input logic [SIZE-1:0] next_w, input bit b2b, input bit rnd_pause);
    int waits;
    int done_at;
    int start_dones;
    int n_obs;
    int n_exp;
    logic [31:0] obs_l, obs_i, exp_l, exp_i;
    waits = 0; done_at = -1; n_obs = 0; obs_l = '0; obs_i = '0;
    while (bus.in_ready !== 1'b1 && waits < 64) begin
      tick();
      waits++;
    end
    check("ready_timeout", 32'(waits < 64), 32'd1);
    if (b2b) check("b2b_first_ready", 32'(waits), 32'd0);
    bus.in_valid = 1'b1;
    bus.din      = w;
    tick();
    start_dones = done_cnt;
    for (int k = 1; k < 64; k++) begin
      bus.in_valid = 1'b0;
      bus.din      = SIZE'($urandom);
      bus.pause    = (pl > 0 && k >= ps && k < ps + pl);
      if (k == 1) begin
        if (rnd_pause) bus.pause = 1'($urandom);
        check("clear_pulse", 32'(bus.sfr_clr), 32'd1);
        check("clear_busy",  32'(bus.busy),    32'd1);
      end
      if (k == junk_k) begin
        check("busy_not_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.din      = 8'h3C;
      end
      if (k == abort_k) begin
        #2 clr = 1'b1;
        #1 check_idle_outputs("abort");
        #2 clr = 1'b0;
        bus.pause    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (12) tick();
        check("abort_no_done", 32'(done_cnt), 32'(start_dones));
        check("abort_ready",   32'(bus.in_ready), 32'd1);
        return;
      end
      if (bus.done === 1'b1) begin
        done_at = k;
        if (chain) begin
          bus.in_valid = 1'b1;
          bus.din      = next_w;
        end
        break;
      end
      if (k >= 2) begin
        obs_l = {obs_l[30:0], bus.sfr_left};
        obs_i = {obs_i[30:0], bus.sfr_incr};
        n_obs++;
      end
      tick();
    end
    bus.pause = 1'b0;
    exp_stream(w, ps, pl, exp_l, exp_i, n_exp);
    check("done_cycle",  32'(done_at), 32'(int'(SIZE) + 2 + pl));
    check("sfr_q",       32'(q),       32'(w));
    check("stream_len",  32'(n_obs),   32'(n_exp));
    check("left_seq",    obs_l,        exp_l);
    check("incr_seq",    obs_i,        exp_i);
    tick();
    check("done_once",   32'(done_cnt), 32'(start_dones + 1));
    check("done_pulse",  32'(bus.done), 32'd0);
    check("idle_ready",  32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.pause    = 1'b0;
    clr          = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    #2 clr = 1'b0;
    tick();
    bus.pause = 1'b1;
    tick();
    check_idle_outputs("idle_pause");
    bus.pause = 1'b0;

    send_word(8'hA5, 0, 0, 0, 0, 1'b0, '0,    1'b0, 1'b0);
    send_word(8'h00, 0, 0, 0, 0, 1'b1, 8'hFF, 1'b0, 1'b0);
    send_word(8'hFF, 0, 0, 0, 0, 1'b0, '0,    1'b1, 1'b0);
    send_word(8'h81, 5, 3, 0, 0, 1'b0, '0,    1'b0, 1'b0);
    send_word(8'h5A, 0, 0, 4, 0, 1'b0, '0,    1'b0, 1'b0);
    send_word(8'hC3, 0, 0, 0, 6, 1'b0, '0,    1'b0, 1'b0);
    send_word(8'h17, 0, 0, 0, 0, 1'b0, '0,    1'b0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      logic [SIZE-1:0] w;
      int ps;
      int pl;
      w  = SIZE'($urandom);
      ps = int'($urandom_range(2, SIZE));
      pl = int'($urandom_range(0, 3));
      send_word(w, ps, pl, 0, 0, 1'b0, '0, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sfr_word_tx.md
# sfr_word_tx

Transmit side of the shift-register SFR link. Accepts a parallel word over a valid/ready handshake and drives the clear/shift/increment control stream that makes a downstream left-shift SFR rebuild the same word, MSB first. The block sits between a word-producing master and the SFR's `clr`/`left`/`incr` inputs, replacing ad-hoc software toggling of those pins.

## Interface
- `SIZE`, default 32: word width. Must be ≥ 2.
- `CNT_W`, default `$clog2(SIZE)`: bit-counter width. Localparam, not overridable.
- `clk` input 1: clock. All state updates on the rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: the word on `din` is offered.
- `in_ready` output 1: the block can accept a word. High only in IDLE.
- `din` input SIZE: word to transmit. Sampled only on accept.
- `pause` input 1: stalls transmission while high in SEND.
- `sfr_clr` output 1: drives the downstream SFR `clr`.
- `sfr_left` output 1: drives the downstream SFR `left`.
- `sfr_incr` output 1: drives the downstream SFR `incr`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; the downstream SFR holds the complete word.

## Operation
- Reset:
  - state = IDLE; shift register = 0; counter = 0.
  - `in_ready`=1; `sfr_clr`, `sfr_left`, `sfr_incr`, `busy`, `done` = 0.
- Outputs are registered. Each output is a flop, or a decode of the state register only. No combinational path from any input to any output.
- Accept occurs when `in_valid && in_ready`. The block loads `din` into its internal shift register `sr`, then moves to CLEAR.
- States and transitions:
  - IDLE: `in_ready`=1. On accept, go to CLEAR.
  - CLEAR: `sfr_clr`=1 for exactly one cycle. Set counter = SIZE-1. Go to SEND.
  - SEND: `sfr_incr` = `sr[SIZE-1]`.
    - `sfr_left`=1 while counter ≠ 0, and 0 on the final bit (counter = 0).
    - Each non-paused cycle: shift `sr` left by one, filling a 0, and decrement the counter.
    - After the counter = 0 cycle, go to DONE.
  - DONE: `done`=1 for one cycle. Go to IDLE.
- Pause handling:
  - `pause`=1 in SEND forces `sfr_left`=`sfr_incr`=0 on the next cycle. `sr` and the counter hold.
  - Resume is seamless: no bit is repeated or dropped.
  - `pause` has no effect in IDLE, CLEAR or DONE.
- Downstream arithmetic: each SEND step yields Q ← (Q + b) << 1, or Q ← Q + b on the last bit. After SIZE steps, Q equals `din`. The increment never carries, because the LSB is always 0 after a shift.
- While busy, `in_valid` is ignored and `din` is don't-care. Words are not queued.
- `clr` asserted mid-operation:
  - The block returns immediately to the reset values.
  - The partial downstream word is abandoned.
  - No `done` pulse is produced.

## Timing
- Accept in cycle 0:
  - CLEAR in cycle 1.
  - SEND in cycles 2 … SIZE+1, with no pause.
  - DONE in cycle SIZE+2.
  - IDLE (`in_ready`=1) in cycle SIZE+3.
- Each pause cycle adds one cycle to the latency.
- Minimum accept-to-accept spacing: SIZE+3 cycles. A back-to-back word can be accepted on the first IDLE cycle.
- The downstream SFR Q is valid from the edge ending the last SEND cycle onward. That is, it is valid during and after DONE, until the next CLEAR.
- `sfr_left` and `sfr_incr` may be high in the same cycle. The receiver resolves increment before shift.

## Structure
- Shared package `sfr_pkg` holds:
  - the state encoding localparams `ST_IDLE`, `ST_CLEAR`, `ST_SEND`, `ST_DONE` (2-bit);
  - the handshake documentation constants shared with future SFR link blocks.
- One natural sub-module: `sfr_bit_cnt`.
  - A CNT_W-bit loadable down-counter with hold (for `pause`), asynchronous `clr`, and a `zero` flag.
  - Reusable by a future receive-side sequencer.
- FSM and shift register live in the top module. Estimated 150–250 lines of RTL.

## Test plan
All scenarios use SIZE=8 and connect the bench's left-shift SFR model to `sfr_*`.
- Send `din`=8'hA5:
  - `sfr_incr` sequence 1,0,1,0,0,1,0,1.
  - `sfr_left` sequence 1×7 then 0.
  - `done` in cycle 10 after accept.
  - Model Q = 8'hA5.
- Send 8'h00, then 8'hFF back-to-back (second `in_valid` held high):
  - First Q = 8'h00, second Q = 8'hFF.
  - Second accept occurs exactly on the first cycle `in_ready`=1.
- Send 8'h81 with `pause`=1 for 3 cycles after the 4th SEND bit:
  - `sfr_left`=`sfr_incr`=0 for those 3 cycles.
  - `done` delayed by 3 cycles.
  - Q = 8'h81.
- Pulse `in_valid` with `din`=8'h3C while busy sending 8'h5A:
  - The second word is ignored.
  - Q = 8'h5A.
  - Exactly one `done`.
- Assert `clr` asynchronously (mid-cycle) during the 5th SEND bit of 8'hC3:
  - All outputs drop to their reset values before the next edge.
  - `in_ready`=1.
  - No `done`.
  - A following send of 8'h17 yields Q = 8'h17.
